// File: rtl/ahbl_master_arbiter.sv
// ahbl_master_arbiter
// Shares one AHB-Lite slave port between 2..4 masters (0 = CPU, 1 = DMAC).
// A master that loses arbitration has its address phase buffered and is
// stalled through its own mHREADY, so it never sees a corrupted transfer.
// Fairness is round-robin, with locked-sequence and SEQ-burst hold.
//
// Ports:
//   HCLK, HRESET           clock, synchronous active-high reset
//   mHADDR..mHWDATA        flattened per-master address/control/write data
//   mHREADY, mHRDATA       per-master ready and read data
//   HADDR..HMASTLOCK       slave-side address phase
//   HWDATA                 slave-side write data (from the master in DATA)
//   HREADY, HRDATA         slave-side ready and read data
//   GNT                    one-hot address-phase owner, zero when idle
module ahbl_master_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned W_ADDR    = 32,
    parameter int unsigned W_DATA    = 32
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [N_MASTERS*W_ADDR-1:0] mHADDR,
    input  logic [N_MASTERS*2-1:0]      mHTRANS,
    input  logic [N_MASTERS*3-1:0]      mHSIZE,
    input  logic [N_MASTERS-1:0]        mHWRITE,
    input  logic [N_MASTERS-1:0]        mHMASTLOCK,
    input  logic [N_MASTERS*W_DATA-1:0] mHWDATA,
    output logic [N_MASTERS-1:0]        mHREADY,
    output logic [N_MASTERS*W_DATA-1:0] mHRDATA,
    output logic [W_ADDR-1:0]           HADDR,
    output logic [1:0]                  HTRANS,
    output logic [2:0]                  HSIZE,
    output logic                        HWRITE,
    output logic                        HMASTLOCK,
    output logic [W_DATA-1:0]           HWDATA,
    input  logic                        HREADY,
    input  logic [W_DATA-1:0]           HRDATA,
    output logic [N_MASTERS-1:0]        GNT
);
    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    typedef enum logic [1:0] {StFree, StPend, StData} state_e;

    // Effective request per master: the buffer while PEND, live inputs otherwise.
    logic [N_MASTERS*W_ADDR-1:0] cur_addr;
    logic [N_MASTERS*2-1:0]      cur_trans;
    logic [N_MASTERS*3-1:0]      cur_size;
    logic [N_MASTERS-1:0]        cur_write;
    logic [N_MASTERS-1:0]        cur_lock;
    logic [N_MASTERS-1:0]        cand;
    logic [N_MASTERS-1:0]        in_data;

    logic [N_MASTERS-1:0] gnt;
    logic [N_MASTERS-1:0] gnt_q;
    logic                 hold_q;
    logic                 lock_q;
    logic [IDX_W-1:0]     rr_q;
    logic [IDX_W-1:0]     lock_id_q;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     data_idx;
    logic [IDX_W-1:0]     rr_idx;
    logic                 rr_found;
    logic                 gnt_any;
    logic                 accept;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_master
        state_e            state_q;
        state_e            state_d;
        logic              capture;
        logic              ready;
        logic              live_req;
        logic              pend;
        logic [W_ADDR-1:0] buf_addr_q;
        logic [1:0]        buf_trans_q;
        logic [2:0]        buf_size_q;
        logic              buf_write_q;
        logic              buf_lock_q;

        assign live_req   = mHTRANS[2*i+1];
        assign pend       = (state_q == StPend);
        assign cand[i]    = pend || live_req;
        assign in_data[i] = (state_q == StData);

        assign cur_addr[i*W_ADDR +: W_ADDR] = pend ? buf_addr_q  : mHADDR[i*W_ADDR +: W_ADDR];
        assign cur_trans[i*2 +: 2]          = pend ? buf_trans_q : mHTRANS[i*2 +: 2];
        assign cur_size[i*3 +: 3]           = pend ? buf_size_q  : mHSIZE[i*3 +: 3];
        assign cur_write[i]                 = pend ? buf_write_q : mHWRITE[i];
        assign cur_lock[i]                  = pend ? buf_lock_q  : mHMASTLOCK[i];

        // Capture only happens when this master sees mHREADY=1, i.e. it
        // believes its address phase was accepted.
        always_comb begin
            state_d = state_q;
            capture = 1'b0;
            ready   = 1'b1;
            case (state_q)
                StFree: begin
                    if (live_req) begin
                        if (gnt[i] && HREADY) begin
                            state_d = StData;
                        end else begin
                            state_d = StPend;
                            capture = 1'b1;
                        end
                    end
                end
                StPend: begin
                    ready = 1'b0;
                    if (gnt[i] && HREADY) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    ready = HREADY;
                    if (HREADY) begin
                        if (!live_req) begin
                            state_d = StFree;
                        end else if (!gnt[i]) begin
                            state_d = StPend;
                            capture = 1'b1;
                        end
                    end
                end
                default: state_d = StFree;
            endcase
        end

        assign mHREADY[i]                  = ready;
        assign mHRDATA[i*W_DATA +: W_DATA] = HRDATA;

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                state_q     <= StFree;
                buf_addr_q  <= '0;
                buf_trans_q <= 2'b00;
                buf_size_q  <= 3'b000;
                buf_write_q <= 1'b0;
                buf_lock_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                if (capture) begin
                    buf_addr_q  <= mHADDR[i*W_ADDR +: W_ADDR];
                    buf_trans_q <= mHTRANS[i*2 +: 2];
                    buf_size_q  <= mHSIZE[i*3 +: 3];
                    buf_write_q <= mHWRITE[i];
                    buf_lock_q  <= mHMASTLOCK[i];
                end
            end
        end
    end

    // Grant: wait-state hold, then lock, then SEQ burst, then round-robin.
    always_comb begin
        gnt      = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        if (hold_q) begin
            gnt = gnt_q;
        end else if (lock_q) begin
            if (cand[lock_id_q]) begin
                gnt[lock_id_q] = 1'b1;
            end
        end else if (cand[rr_q] && (cur_trans[2*rr_q +: 2] == 2'b11)) begin
            gnt[rr_q] = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= N_MASTERS; k++) begin
                rr_idx = IDX_W'((32'(rr_q) + k) % N_MASTERS);
                if (!rr_found && cand[rr_idx]) begin
                    gnt[rr_idx] = 1'b1;
                    rr_found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_idx  = '0;
        data_idx = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDX_W'(i);
            end
            if (in_data[i]) begin
                data_idx = IDX_W'(i);
            end
        end
    end

    assign gnt_any = |gnt;

    always_comb begin
        if (gnt_any) begin
            HADDR     = cur_addr[gnt_idx*W_ADDR +: W_ADDR];
            HTRANS    = cur_trans[gnt_idx*2 +: 2];
            HSIZE     = cur_size[gnt_idx*3 +: 3];
            HWRITE    = cur_write[gnt_idx];
            HMASTLOCK = cur_lock[gnt_idx];
        end else begin
            // Idle bus: keep the lock indication and park on master 0's values.
            HADDR     = mHADDR[W_ADDR-1:0];
            HTRANS    = 2'b00;
            HSIZE     = mHSIZE[2:0];
            HWRITE    = mHWRITE[0];
            HMASTLOCK = lock_q;
        end
    end

    assign HWDATA = mHWDATA[data_idx*W_DATA +: W_DATA];
    assign GNT    = gnt;
    assign accept = HREADY && gnt_any && HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            gnt_q     <= '0;
            hold_q    <= 1'b0;
            lock_q    <= 1'b0;
            rr_q      <= '0;
            lock_id_q <= '0;
        end else begin
            gnt_q  <= gnt;
            hold_q <= !HREADY && HTRANS[1];
            if (accept) begin
                rr_q      <= gnt_idx;
                lock_q    <= HMASTLOCK;
                lock_id_q <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Directed bench for ahbl_master_arbiter with two masters (CPU = 0, DMAC = 1).
module tb_ahbl_master_arbiter;
    logic        HCLK;
    logic        HRESET;
    logic [63:0] mHADDR;
    logic [3:0]  mHTRANS;
    logic [5:0]  mHSIZE;
    logic [1:0]  mHWRITE;
    logic [1:0]  mHMASTLOCK;
    logic [63:0] mHWDATA;
    logic [1:0]  mHREADY;
    logic [63:0] mHRDATA;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [1:0]  GNT;

    int compared;
    int mismatched;

    ahbl_master_arbiter #(
        .N_MASTERS(2),
        .W_ADDR   (32),
        .W_DATA   (32)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .mHADDR    (mHADDR),
        .mHTRANS   (mHTRANS),
        .mHSIZE    (mHSIZE),
        .mHWRITE   (mHWRITE),
        .mHMASTLOCK(mHMASTLOCK),
        .mHWDATA   (mHWDATA),
        .mHREADY   (mHREADY),
        .mHRDATA   (mHRDATA),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .GNT       (GNT)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic set_m(input int m, input logic [31:0] addr, input logic [1:0] trans,
                         input logic wr, input logic lk, input logic [31:0] wd);
        mHADDR[m*32 +: 32]  = addr;
        mHTRANS[m*2 +: 2]   = trans;
        mHSIZE[m*3 +: 3]    = 3'b010;
        mHWRITE[m]          = wr;
        mHMASTLOCK[m]       = lk;
        mHWDATA[m*32 +: 32] = wd;
    endtask

    task automatic idle_all();
        set_m(0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        set_m(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        HREADY = 1'b1;
        idle_all();
        step();
        step();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        compared++;
        if (mHREADY !== 2'b11) begin
            mismatched++; $display("FAIL reset_mhready: got %b want 11", mHREADY);
        end
        compared++;
        if (HTRANS !== 2'b00) begin
            mismatched++; $display("FAIL reset_htrans: got %b want 00", HTRANS);
        end
        compared++;
        if (GNT !== 2'b00) begin
            mismatched++; $display("FAIL reset_gnt: got %b want 00", GNT);
        end
        compared++;
        if (HMASTLOCK !== 1'b0) begin
            mismatched++; $display("FAIL reset_hmastlock: got %b want 0", HMASTLOCK);
        end
        step();
    endtask

    task automatic test_solo_cpu();
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_m(0, addrs[i], 2'b10, 1'b0, 1'b0, 32'h0);
            #1;
            compared++;
            if (GNT !== 2'b01) begin
                mismatched++; $display("FAIL solo_gnt[%0d]: got %b want 01", i, GNT);
            end
            compared++;
            if (HADDR !== addrs[i]) begin
                mismatched++; $display("FAIL solo_haddr[%0d]: got %h want %h", i, HADDR, addrs[i]);
            end
            compared++;
            if (HTRANS !== 2'b10) begin
                mismatched++; $display("FAIL solo_htrans[%0d]: got %b want 10", i, HTRANS);
            end
            compared++;
            if (mHREADY[0] !== 1'b1) begin
                mismatched++; $display("FAIL solo_mhready[%0d]: got %b want 1", i, mHREADY[0]);
            end
            step();
        end
        idle_all();
        #1;
        compared++;
        if (GNT !== 2'b00 || HTRANS !== 2'b00) begin
            mismatched++; $display("FAIL solo_idle: got gnt %b htrans %b want 00 00", GNT, HTRANS);
        end
        compared++;
        if (mHRDATA[31:0] !== 32'h1234_5678) begin
            mismatched++; $display("FAIL solo_hrdata: got %h want 12345678", mHRDATA[31:0]);
        end
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_m(0, 32'h2000_0010, 2'b10, 1'b0, 1'b0, 32'h0);
        set_m(1, 32'h3000_0000, 2'b10, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b10 || HADDR !== 32'h3000_0000) begin
            mismatched++; $display("FAIL simul_first: got gnt %b addr %h want 10 30000000", GNT, HADDR);
        end
        compared++;
        if (mHREADY !== 2'b11) begin
            mismatched++; $display("FAIL simul_rdy0: got %b want 11", mHREADY);
        end
        step();
        // CPU moves on; the arbiter must issue the buffered copy.
        set_m(0, 32'hFFFF_FFF0, 2'b00, 1'b0, 1'b0, 32'h0);
        set_m(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b01 || HADDR !== 32'h2000_0010 || HTRANS !== 2'b10) begin
            mismatched++;
            $display("FAIL simul_buffered: got gnt %b addr %h trans %b want 01 20000010 10",
                     GNT, HADDR, HTRANS);
        end
        compared++;
        if (mHREADY !== 2'b10) begin
            mismatched++; $display("FAIL simul_rdy1: got %b want 10", mHREADY);
        end
        step();
        idle_all();
        #1;
        compared++;
        if (mHREADY !== 2'b11 || GNT !== 2'b00) begin
            mismatched++; $display("FAIL simul_done: got rdy %b gnt %b want 11 00", mHREADY, GNT);
        end
        step();
    endtask

    task automatic test_wait_states();
        do_reset();
        HREADY = 1'b0;
        set_m(1, 32'h4000_0000, 2'b10, 1'b1, 1'b0, 32'hDEAD_BEEF);
        set_m(0, 32'h1000_0000, 2'b10, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b10 || HADDR !== 32'h4000_0000 || HWRITE !== 1'b1) begin
            mismatched++;
            $display("FAIL wait_a: got gnt %b addr %h wr %b want 10 40000000 1", GNT, HADDR, HWRITE);
        end
        step();
        set_m(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'hDEAD_BEEF);
        set_m(0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            HREADY = (c == 2);
            #1;
            compared++;
            if (GNT !== 2'b10 || HADDR !== 32'h4000_0000 || HTRANS !== 2'b10) begin
                mismatched++;
                $display("FAIL wait_hold[%0d]: got gnt %b addr %h trans %b want 10 40000000 10",
                         c, GNT, HADDR, HTRANS);
            end
            compared++;
            if (mHREADY[0] !== 1'b0) begin
                mismatched++; $display("FAIL wait_cpu_stall[%0d]: got %b want 0", c, mHREADY[0]);
            end
            step();
        end
        HREADY = 1'b0;
        #1;
        compared++;
        if (HWDATA !== 32'hDEAD_BEEF) begin
            mismatched++; $display("FAIL wait_wdata0: got %h want deadbeef", HWDATA);
        end
        compared++;
        if (GNT !== 2'b01 || HADDR !== 32'h1000_0000 || mHREADY !== 2'b00) begin
            mismatched++;
            $display("FAIL wait_cpu_e: got gnt %b addr %h rdy %b want 01 10000000 00",
                     GNT, HADDR, mHREADY);
        end
        step();
        HREADY = 1'b1;
        #1;
        compared++;
        if (HWDATA !== 32'hDEAD_BEEF) begin
            mismatched++; $display("FAIL wait_wdata1: got %h want deadbeef", HWDATA);
        end
        compared++;
        if (GNT !== 2'b01 || HADDR !== 32'h1000_0000 || mHREADY !== 2'b10) begin
            mismatched++;
            $display("FAIL wait_cpu_f: got gnt %b addr %h rdy %b want 01 10000000 10",
                     GNT, HADDR, mHREADY);
        end
        step();
        #1;
        compared++;
        if (mHREADY !== 2'b11 || GNT !== 2'b00) begin
            mismatched++; $display("FAIL wait_end: got rdy %b gnt %b want 11 00", mHREADY, GNT);
        end
        step();
    endtask

    task automatic test_lock();
        do_reset();
        set_m(1, 32'h5000_0000, 2'b10, 1'b0, 1'b1, 32'h0);
        set_m(0, 32'h6000_0000, 2'b10, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b10 || HMASTLOCK !== 1'b1) begin
            mismatched++; $display("FAIL lock_first: got gnt %b lock %b want 10 1", GNT, HMASTLOCK);
        end
        step();
        // Locked master goes quiet: bus stays idle, CPU still stalled.
        set_m(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        set_m(0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b00 || HTRANS !== 2'b00 || HMASTLOCK !== 1'b1) begin
            mismatched++;
            $display("FAIL lock_gap: got gnt %b trans %b lock %b want 00 00 1", GNT, HTRANS, HMASTLOCK);
        end
        compared++;
        if (mHREADY[0] !== 1'b0) begin
            mismatched++; $display("FAIL lock_cpu_stall: got %b want 0", mHREADY[0]);
        end
        step();
        set_m(1, 32'h5000_0004, 2'b10, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b10 || HADDR !== 32'h5000_0004 || HMASTLOCK !== 1'b0) begin
            mismatched++;
            $display("FAIL lock_second: got gnt %b addr %h lock %b want 10 50000004 0",
                     GNT, HADDR, HMASTLOCK);
        end
        step();
        set_m(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b01 || HADDR !== 32'h6000_0000) begin
            mismatched++; $display("FAIL lock_cpu: got gnt %b addr %h want 01 60000000", GNT, HADDR);
        end
        step();
        #1;
        compared++;
        if (GNT !== 2'b00 || HMASTLOCK !== 1'b0) begin
            mismatched++; $display("FAIL lock_end: got gnt %b lock %b want 00 0", GNT, HMASTLOCK);
        end
        step();
    endtask

    task automatic test_burst();
        do_reset();
        set_m(1, 32'h7000_0000, 2'b10, 1'b0, 1'b0, 32'h0);
        set_m(0, 32'h8000_0000, 2'b10, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b10) begin
            mismatched++; $display("FAIL burst_beat0: got gnt %b want 10", GNT);
        end
        step();
        set_m(0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        for (int b = 1; b < 4; b++) begin
            set_m(1, 32'h7000_0000 + 32'(4 * b), 2'b11, 1'b0, 1'b0, 32'h0);
            #1;
            compared++;
            if (GNT !== 2'b10 || HADDR !== 32'h7000_0000 + 32'(4 * b) || HTRANS !== 2'b11) begin
                mismatched++;
                $display("FAIL burst_beat%0d: got gnt %b addr %h trans %b want 10 %h 11",
                         b, GNT, HADDR, HTRANS, 32'h7000_0000 + 32'(4 * b));
            end
            compared++;
            if (mHREADY[0] !== 1'b0) begin
                mismatched++; $display("FAIL burst_cpu_stall%0d: got %b want 0", b, mHREADY[0]);
            end
            step();
        end
        set_m(1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b01 || HADDR !== 32'h8000_0000) begin
            mismatched++; $display("FAIL burst_cpu: got gnt %b addr %h want 01 80000000", GNT, HADDR);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(0, 32'h9000_0000, 2'b10, 1'b0, 1'b0, 32'h0);
        set_m(1, 32'hA000_0000, 2'b10, 1'b0, 1'b0, 32'h0);
        #1;
        compared++;
        if (GNT !== 2'b10) begin
            mismatched++; $display("FAIL rstmid_setup: got gnt %b want 10", GNT);
        end
        step();
        idle_all();
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        #1;
        compared++;
        if (HTRANS !== 2'b00 || mHREADY !== 2'b11 || GNT !== 2'b00) begin
            mismatched++;
            $display("FAIL rstmid_after: got trans %b rdy %b gnt %b want 00 11 00",
                     HTRANS, mHREADY, GNT);
        end
        step();
        #1;
        compared++;
        if (HTRANS !== 2'b00 || GNT !== 2'b00) begin
            mismatched++;
            $display("FAIL rstmid_discard: got trans %b gnt %b want 00 00", HTRANS, GNT);
        end
        step();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        HRESET     = 1'b1;
        HREADY     = 1'b1;
        HRDATA     = 32'h1234_5678;
        idle_all();
        test_reset();
        test_solo_cpu();
        test_simultaneous();
        test_wait_states();
        test_lock();
        test_burst();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ahbl_master_arbiter.md
# ahbl_master_arbiter

Two-to-four-master AHB-Lite arbiter that shares one AHB-Lite slave port (the SoC address decoder/slave mux) between the CPU and the DMAC. It replaces the fixed-master hookup where the DMAC stalls the CPU through a side-band `stop` signal. Losing masters have their address phases buffered, so the CPU is never corrupted when the DMAC wins the bus. Fairness is round-robin, with lock and burst (SEQ) hold.

## Interface
- N_MASTERS, 2: number of masters, legal range 2..4; index 0 = CPU, 1 = DMAC.
- W_ADDR, 32: address width.
- W_DATA, 32: data width.

Ports:
- HCLK  in  1  clock; the only clock.
- HRESET  in  1  synchronous, active-high reset.
- mHADDR  in  N_MASTERS*W_ADDR  master address, flattened; master i at [i*W_ADDR +: W_ADDR].
- mHTRANS  in  N_MASTERS*2  master transfer type.
- mHSIZE  in  N_MASTERS*3  master size.
- mHWRITE  in  N_MASTERS  master write.
- mHMASTLOCK  in  N_MASTERS  master lock request.
- mHWDATA  in  N_MASTERS*W_DATA  master write data.
- mHREADY  out  N_MASTERS  per-master ready.
- mHRDATA  out  N_MASTERS*W_DATA  per-master read data.
- HADDR, HTRANS, HSIZE, HWRITE, HMASTLOCK  out  W_ADDR/2/3/1/1  slave-side address phase.
- HWDATA  out  W_DATA  slave-side write data.
- HREADY  in  1  slave-side ready (from the slave mux HREADYOUT).
- HRDATA  in  W_DATA  slave-side read data.
- GNT  out  N_MASTERS  one-hot address-phase owner; all zero when the bus is idle.

## Operation
- A master is "requesting" when its HTRANS[1] is 1. HRESP is not supported; all transfers complete OKAY.
- Each master has a 2-bit FSM: FREE, PEND, DATA. It also has a buffer holding HADDR/HTRANS/HSIZE/HWRITE/HMASTLOCK.
- **FREE**
  - mHREADY[i]=1.
  - On an edge where the master is requesting: go to DATA if it is granted with a live address and HREADY=1.
  - Otherwise capture its address phase into the buffer and go to PEND.
- **PEND**
  - mHREADY[i]=0.
  - The slave sees the buffer contents when granted.
  - On an edge where it is granted and HREADY=1: go to DATA.
- **DATA**
  - mHREADY[i]=HREADY; mHRDATA[i]=HRDATA; HWDATA=mHWDATA[i].
  - On an edge with HREADY=1, the transfer completes. The master's next address (if requesting) follows the FREE rule; otherwise go to FREE.
- At most one master is in DATA at any time.
- Non-DATA masters see mHRDATA=HRDATA (don't-care).
- Candidates:
  - Every PEND master.
  - Every FREE or DATA master that is requesting live.
- Grant selection, in priority order:
  - (a) **Hold**: if hold_q=1, keep gnt_q.
  - (b) **Lock**: if lock_q=1, grant only lock_id. If lock_id is not a candidate, grant none.
  - (c) **Burst**: if the last accepted master's current request is SEQ, grant it.
  - (d) **Round-robin**: search starts at rr_q+1 mod N_MASTERS.
- Registered state, updated on every edge:
  - hold_q <= (HREADY==0 && HTRANS[1]).
  - gnt_q <= current grant.
- On an HREADY=1 edge with an accepted transfer from master g:
  - rr_q <= g.
  - lock_q <= the accepted HMASTLOCK.
  - lock_id <= g.
- On an HREADY=1 edge with no grant, lock_q is unchanged.
- With no grant: HTRANS=IDLE, HMASTLOCK=lock_q, and the other address outputs carry master 0's live values.

## Timing
- **Reset (HRESET=1 at an edge)**:
  - All FSMs go to FREE.
  - gnt_q, hold_q, lock_q, rr_q and lock_id are cleared.
  - After reset: mHREADY all 1, HTRANS=0, GNT=0, HMASTLOCK=0.
  - A reset mid-transfer discards buffered and in-flight transfers.
- **Latency**:
  - A granted live address reaches the slave combinationally in the same cycle (zero added latency).
  - A PEND transfer reaches the slave no earlier than the cycle after capture (+1 cycle).
- **Wait states**: address outputs stay stable while HREADY=0 with an active HTRANS. This is enforced by hold_q.
- **Buffer capture**: happens only on edges where mHREADY[i]=1. The buffer is stable throughout PEND.
- **Simultaneous events**:
  - A DATA completion and a new grant at the same edge are legal. The old owner leaves DATA and the new owner enters DATA in that edge.
  - Two FREE masters requesting in the same cycle: the round-robin winner goes to DATA and the loser goes to PEND.
- **Starvation bound**: with no lock or SEQ, a PEND master is granted within N_MASTERS-1 accepted transfers.

## Test plan
- Solo CPU, back-to-back NONSEQ reads 0x0, 0x4, 0x8 with HREADY=1:
  - Slave sees each address in the same cycle it is issued.
  - mHREADY[0] never deasserts; GNT=01 each cycle.
- CPU and DMAC NONSEQ in the same cycle, rr_q=0 after reset:
  - DMAC granted first.
  - CPU buffered (mHREADY[0]=0 for 1 cycle), then issued next cycle with its original address 0x2000_0010 unchanged.
- Slave inserts 3 wait states on a DMAC write 0x4000_0000/0xDEADBEEF while the CPU requests:
  - HADDR is held stable for all 4 cycles.
  - The CPU is granted only after the HREADY=1 edge.
  - HWDATA=0xDEADBEEF throughout the data phase.
- DMAC locked pair (HMASTLOCK=1 then 0) while the CPU requests continuously:
  - The CPU is not granted until the unlocked DMAC transfer is accepted.
- DMAC 4-beat NONSEQ/SEQ/SEQ/SEQ with the CPU requesting:
  - No CPU grant between the beats.
  - CPU granted on the cycle after beat 4 is accepted.
- Assert HRESET while the CPU is in PEND and the DMAC is in DATA:
  - Next cycle: HTRANS=0, mHREADY=11, GNT=00.
  - The buffered CPU transfer is never issued.
